// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch front end.
package rv_fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // A fetchable PC is word aligned and addresses a word that exists in the ROM.
  function automatic logic pc_fetchable(input logic [PC_W-1:0] pc, input int unsigned addr_w);
    return (pc[1:0] == 2'b00) && ((pc >> (addr_w + 2)) == '0);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with redirect / +4 / hold next-PC selection and
// an alignment/range check on the current PC.
module fetch_pc_gen
  import rv_fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 12,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_ok_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i)
      pc_d = redirect_pc_i;
    else if (advance_i)
      pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign pc_o    = pc_q;
  assign pc_ok_o = pc_fetchable(pc_q, ADDR_W);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: drives the ROM word address from the PC and
// registers the returned word toward decode with a valid/ready handshake.
//
//   state | meaning
//   RUN   | fetching; a word is captured whenever the output slot is free
//   FAULT | fetch halted on a misaligned or out-of-range PC; left only by redirect or reset
module instr_fetch
  import rv_fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 12,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fetch_fault
);

  fetch_state_t       state_q;
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [PC_W-1:0]    out_pc_q;
  logic               fault_q;

  logic [PC_W-1:0]    pc;
  logic               pc_ok;
  logic               load;

  assign load = (state_q == RUN) && !redirect_valid && (!out_valid_q || out_ready);

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .advance_i        (load && pc_ok),
    .pc_o             (pc),
    .pc_ok_o          (pc_ok)
  );

  assign rom_addr = pc[ADDR_W+1:2];

  // Redirect flushes the output slot even if decode takes the word this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      fault_q     <= 1'b0;
    end else if (redirect_valid) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else if (load) begin
      if (pc_ok) begin
        out_instr_q <= rom_data;
        out_pc_q    <= pc;
        out_valid_q <= 1'b1;
      end else begin
        state_q     <= FAULT;
        out_valid_q <= 1'b0;
        fault_q     <= 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch initiator for the RV32 core; it is the reader side of the combinational instruction ROM.
- Holds the program counter (PC) and drives the ROM word address.
- Captures the returned word into a registered output stage with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute and flags out-of-range or misaligned fetches.

Parameters:
- ADDR_W, 12, ROM word-address width (ROM depth = 2**ADDR_W words).
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- rom_addr  output  ADDR_W  word address to the ROM, = pc_q[ADDR_W+1:2], combinational from pc_q.
- rom_data  input  32  ROM read data, combinational, valid in the same cycle.
- redirect_valid  input  1  load a new PC this cycle.
- redirect_pc  input  32  byte target PC.
- out_valid  output  1  out_instr/out_pc hold a fetched instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  byte PC of out_instr.
- fetch_fault  output  1  high while in FAULT.

Behaviour:
- Reset values (async, while rst_n=0): pc_q=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_fault=0, state=RUN.
- States:
  - RUN: normal fetch.
  - FAULT: fetch halted.
- Fetch condition: load = (state==RUN) && !redirect_valid && (!out_valid || out_ready).
- On load at a rising edge:
  - Good PC (pc_q[1:0]==0 and pc_q[31:ADDR_W+2]==0): out_instr<=rom_data, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+4 (32-bit wrap).
  - Bad PC: state<=FAULT, out_valid<=0, pc_q unchanged.
- Stall: out_valid=1 && out_ready=0 && !redirect_valid → all registers hold; out_instr and out_pc are stable.
- Redirect (highest priority, any state): pc_q<=redirect_pc, out_valid<=0 (flush the held instruction even if out_ready=1 that cycle), state<=RUN, fetch_fault<=0.
- A misaligned or out-of-range redirect_pc enters FAULT on the next load attempt, not on the redirect cycle.
- Latency:
  - First instruction is out_valid on the 1st rising edge after rst_n deasserts.
  - After a redirect at edge N, the target instruction is out_valid after edge N+1.
  - Sustained throughput is 1 instruction/cycle with out_ready held high.
- FAULT: out_valid=0, fetch_fault=1, rom_addr still reflects pc_q. The only exits are a redirect or reset.
- PC wrap: pc_q=32'hFFFF_FFFC increments to 0.
  - The last valid ROM word (pc=4*(2**ADDR_W-1)) increments to 4*2**ADDR_W, which faults on the next load.
- Simultaneous redirect_valid and out_ready with out_valid=1: the handshake completes (decode consumes the word), the redirect wins for PC, and no new word is loaded that edge.
- Reset mid-stall or mid-fault: returns immediately to reset values.

Decomposition:
- Shared package rv_fetch_pkg:
  - fetch_state_t enum {RUN, FAULT}.
  - Constants INSTR_W=32, PC_W=32, RESET_PC_DEFAULT.
- One natural sub-module: fetch_pc_gen.
  - Contains the PC register, next-PC mux (redirect / +4 / hold) and range/alignment check.
  - The top level owns the output register and FSM.

Test Plan:
- ROM words 0..4 = 00000293, 00128293, 00502023, 00002303, FF5FF0EF; release reset with out_ready=1 → out_pc 0,4,8,C,10 on consecutive edges, out_instr matching, rom_addr 0..4.
- out_ready=0 for 3 cycles while out_pc=8 → out_instr holds 00502023 and pc_q holds C; resume → next out_pc=C.
- Redirect to 0x4 while out_valid=1 (out_pc=10) → next cycle out_valid=0, following cycle out_pc=4, out_instr=00128293.
- Redirect to 0x6 → after one cycle fetch_fault=1, out_valid=0; redirect to 0x0 → fault clears and out_pc=0 appears two edges later.
- Redirect to 0x3FFC (ADDR_W=12), out_ready=1 → one valid fetch at 3FFC, then FAULT at 0x4000.
- Assert rst_n=0 asynchronously mid-stall → out_valid drops without a clock edge; pc restarts at RESET_PC.
